bilbo_reg: RTL and testbench
============================

BILBO_REG -- requirements
Module: bilbo_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 Parameter POLY, default 8'hB8: WIDTH-bit feedback tap mask; bit i set means q[i] feeds the XOR feedback.
REQ-003 Parameter CNT_W, default 8: width of the session length counter.
REQ-004 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_l  input  1: reset, asynchronous, active-low.
REQ-006 Port d  input  WIDTH: parallel functional data.
REQ-007 Port b1, b2  input  1 each: BILBO mode controls.
REQ-008 Port scan_in  input  1: serial scan data.
REQ-009 Port start  input  1: single-cycle pulse that launches a signature session.
REQ-010 Port len  input  CNT_W: session length in cycles, sampled on start.
REQ-011 Port golden  input  WIDTH: expected signature; used only with BILBO_SIG_CMP_EN.
REQ-012 Port q  output  WIDTH: register contents.
REQ-013 Port scan_out  output  1: equals q[WIDTH-1].
REQ-014 Port busy  output  1: high while the state is RUN.
REQ-015 Port done  output  1: high while the state is DONE.
REQ-016 Port sig_match  output  1: signature compare result.

Function
REQ-017 State machine SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered or derived from registered state.
REQ-018 In IDLE, b1b2=11 (normal) SHALL load q<=d.
REQ-019 In IDLE, b1b2=00 (scan) SHALL load q<={q[WIDTH-2:0],scan_in}.
REQ-020 In IDLE, b1b2=10 (MISR) SHALL apply fb=^(q&POLY), q[0]<=d[0]^fb, and q[i]<=d[i]^q[i-1] for i>=1.
REQ-021 In IDLE, b1b2=01 (clear) SHALL load q<=0.
REQ-022 In IDLE, start=1 with len!=0 SHALL load counter<=len and move to RUN on the same edge; the mode update for that edge SHALL still apply.
REQ-023 In IDLE, start=1 with len==0 SHALL be ignored.
REQ-024 In RUN, q SHALL apply the MISR update regardless of b1/b2, and the counter SHALL decrement once per cycle.
REQ-025 RUN SHALL last exactly len cycles, then move to DONE: busy stays high for len cycles starting one cycle after start.
REQ-026 In RUN, start SHALL be ignored.
REQ-027 In DONE, q SHALL hold, except that b1b2=00 SHALL shift as in scan mode and move the state to IDLE.
REQ-028 In DONE, start=1 with len!=0 SHALL reload the counter and return to RUN; start takes priority over b1b2=00.
REQ-029 Counter arithmetic SHALL be unsigned CNT_W-bit; len=2^CNT_W-1 SHALL be supported without wrap.
REQ-030 scan_out SHALL equal q[WIDTH-1] combinationally in every state.

Reset
REQ-031 rst_l=0 SHALL asynchronously force q=0, counter=0, state=IDLE, busy=0, done=0 and sig_match=0.
REQ-032 Reset asserted mid-session SHALL abort the session immediately; after release the block SHALL be in IDLE with no pending start.
REQ-033 Reset SHALL be released synchronously externally; the block SHALL add no reset synchroniser.

Configuration
REQ-034 Macro BILBO_SIG_CMP_EN, when defined, SHALL make sig_match a register set on the RUN->DONE edge to (next q == golden), held through DONE, and cleared on leaving DONE.
REQ-035 Without BILBO_SIG_CMP_EN, sig_match SHALL be tied 0, golden SHALL be unused, and no comparator SHALL be instantiated.

Verification
REQ-036 Scan: WIDTH=4, after reset, b1b2=00, scan_in 1,0,1,1 over 4 cycles -> q=4'b1011 and scan_out=1.
REQ-037 MISR step: WIDTH=4, POLY=4'b1001, q=4'b0001, d=0, b1b2=10, one clock -> q=4'b0011.
REQ-038 Session: start with len=3 -> busy high exactly 3 cycles; done rises on the 4th edge after start; q then holds across 5 further cycles with b1b2=10.
REQ-039 Edge cases: start with len=0 -> stays IDLE, busy=0; start pulsed during RUN -> session length unchanged.
REQ-040 Reset mid-RUN: rst_l low for 1 cycle at count 2 -> q=0, busy=0, done=0 immediately; IDLE after release.
REQ-041 With BILBO_SIG_CMP_EN, golden set to the signature computed by the model -> sig_match=1 in DONE; golden with one bit flipped -> sig_match=0.

Source files
------------

// File: rtl/bilbo_reg.sv
// ---------------------------------------------------------------------------
// bilbo_reg
//
// Built-In Logic Block Observer register with a small session controller.
//
// While IDLE the register behaves as a classic BILBO, selected by {b1,b2}:
//   11 normal  : q <= d
//   00 scan    : q <= {q[WIDTH-2:0], scan_in}
//   10 MISR    : multiple-input signature compression of d into q
//   01 clear   : q <= 0
//
// A start pulse with a non-zero len launches a signature session: the block
// spends exactly len cycles in RUN compressing d into q (MISR mode forced),
// then parks in DONE holding the signature until it is either scanned out
// (b1b2=00, which also returns to IDLE) or a new session is started.
//
// Optional feature: define BILBO_SIG_CMP_EN to build a signature comparator
// that registers (signature == golden) when the session ends. Without the
// macro sig_match is tied low and golden is ignored.
//
// Parameters:
//   WIDTH  register width (>= 2)
//   POLY   WIDTH-bit feedback tap mask, bit i set = q[i] feeds the XOR
//   CNT_W  width of the session length counter
//
// Ports:
//   clock      rising-edge clock
//   rst_l      asynchronous active-low reset (release is synchronised outside)
//   d          parallel functional data / MISR input
//   b1, b2     BILBO mode select
//   scan_in    serial scan input
//   start      single-cycle session launch pulse
//   len        session length in cycles, sampled with start
//   golden     expected signature (comparator build only)
//   q          register contents
//   scan_out   serial scan output, always q[WIDTH-1]
//   busy       high while a session is running
//   done       high while a finished signature is being held
//   sig_match  registered signature compare result
// ---------------------------------------------------------------------------
module bilbo_reg #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = 8'hB8,
  parameter int                 CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] d,
  input  logic             b1,
  input  logic             b2,
  input  logic             scan_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic             busy,
  output logic             done,
  output logic             sig_match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] misr_val;
  logic             feedback;
  logic             launch;

  // Candidate next values for the register, shared by every state.
  // The MISR folds the tapped bits into bit 0 and XORs the shifted register
  // with the parallel data so every input bit influences the signature.
  always_comb begin
    feedback  = ^(q_q & POLY);
    shift_val = {q_q[WIDTH-2:0], scan_in};
    misr_val  = {q_q[WIDTH-2:0] ^ d[WIDTH-1:1], d[0] ^ feedback};
  end

  // A zero-length request would produce an empty session, so it is dropped.
  assign launch = start && (len != '0);

  // Next-state, register and counter logic.
  // The counter holds the number of RUN cycles still to go; the last RUN
  // cycle is the one where it reads 1, so RUN lasts exactly len cycles and
  // len = 2^CNT_W-1 never needs the counter to wrap.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        unique case ({b1, b2})
          2'b11:   q_d = d;
          2'b00:   q_d = shift_val;
          2'b10:   q_d = misr_val;
          default: q_d = '0;
        endcase
        // The mode update above still applies on the launching edge.
        if (launch) begin
          cnt_d   = len;
          state_d = RUN;
        end
      end

      RUN: begin
        q_d   = misr_val;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // A new session wins over a scan-out request; the signature is left
        // untouched so the next session continues compressing from it.
        if (launch) begin
          cnt_d   = len;
          state_d = RUN;
        end else if ({b1, b2} == 2'b00) begin
          q_d     = shift_val;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, register and counter flops.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q        = q_q;
  assign scan_out = q_q[WIDTH-1];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

`ifdef BILBO_SIG_CMP_EN
  logic sig_match_q, sig_match_d;

  // The comparison uses the value q takes on the session's final edge, so
  // the flag becomes valid in the same cycle that done rises. It is kept for
  // as long as the signature is held and dropped when DONE is left.
  always_comb begin
    sig_match_d = sig_match_q;
    if (state_q == RUN && state_d == DONE) begin
      sig_match_d = (q_d == golden);
    end else if (state_d != DONE) begin
      sig_match_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      sig_match_q <= 1'b0;
    end else begin
      sig_match_q <= sig_match_d;
    end
  end

  assign sig_match = sig_match_q;
`else
  // Comparator not built: golden is deliberately sunk into a dead net.
  logic unused_golden;
  assign unused_golden = ^golden;
  assign sig_match     = 1'b0;
`endif

endmodule

// File: tb/tb_bilbo_reg.sv
// ---------------------------------------------------------------------------
// tb_bilbo_reg
//
// Directed bench for bilbo_reg with WIDTH=4, POLY=4'b1001, CNT_W=8.
// Walks through scan, clear, normal load, MISR steps, zero-length start,
// a full session with a stray start during RUN, DONE hold / scan-out,
// start priority in DONE, reset in the middle of a session and the
// maximum session length. Expected values are worked out by hand from the
// BILBO equations and written as constants next to each step.
// ---------------------------------------------------------------------------
module tb_bilbo_reg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             rst_l;
  logic [WIDTH-1:0] d;
  logic             b1;
  logic             b2;
  logic             scan_in;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] q;
  logic             scan_out;
  logic             busy;
  logic             done;
  logic             sig_match;

  int total;
  int bad;
  int busy_cycles;

  bilbo_reg #(
    .WIDTH (WIDTH),
    .POLY  (4'b1001),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .rst_l     (rst_l),
    .d         (d),
    .b1        (b1),
    .b2        (b2),
    .scan_in   (scan_in),
    .start     (start),
    .len       (len),
    .golden    (golden),
    .q         (q),
    .scan_out  (scan_out),
    .busy      (busy),
    .done      (done),
    .sig_match (sig_match)
  );

  // 10-unit clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge and settle just after it, so outputs are read
  // away from the edge and new inputs are driven well before the next one.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sig_match when the comparator should report a match.
  function automatic logic sig_hit();
`ifdef BILBO_SIG_CMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    rst_l   = 1'b0;
    d       = '0;
    b1      = 1'b1;
    b2      = 1'b1;
    scan_in = 1'b0;
    start   = 1'b0;
    len     = '0;
    golden  = '0;

    // Reset state
    #2;
    checkOutput("reset_q", 32'(q), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_sig", 32'(sig_match), 32'h0);
    checkOutput("reset_scan_out", 32'(scan_out), 32'h0);
    applyStimulus();
    rst_l = 1'b1;

    // Scan 1,0,1,1 -> 0001, 0010, 0101, 1011
    b1 = 1'b0; b2 = 1'b0;
    scan_in = 1'b1; applyStimulus();
    checkOutput("scan_step1", 32'(q), 32'h1);
    scan_in = 1'b0; applyStimulus();
    scan_in = 1'b1; applyStimulus();
    checkOutput("scan_step3", 32'(q), 32'h5);
    scan_in = 1'b1; applyStimulus();
    checkOutput("scan_q", 32'(q), 32'hB);
    checkOutput("scan_out", 32'(scan_out), 32'h1);

    // Clear
    b1 = 1'b0; b2 = 1'b1; applyStimulus();
    checkOutput("clear_q", 32'(q), 32'h0);

    // Normal load
    b1 = 1'b1; b2 = 1'b1; d = 4'b0001; applyStimulus();
    checkOutput("load_q", 32'(q), 32'h1);

    // MISR: 0001,d=0 -> 0011 ; 0011,d=0 -> 0111 ; 0111,d=0101 -> 1010
    b1 = 1'b1; b2 = 1'b0; d = 4'b0000; applyStimulus();
    checkOutput("misr_step1", 32'(q), 32'h3);
    applyStimulus();
    checkOutput("misr_step2", 32'(q), 32'h7);
    d = 4'b0101; applyStimulus();
    checkOutput("misr_step3", 32'(q), 32'hA);

    // start with len=0 is ignored; normal load of the same value keeps q
    b1 = 1'b1; b2 = 1'b1; d = 4'b1010; start = 1'b1; len = 8'd0;
    applyStimulus();
    start = 1'b0;
    checkOutput("len0_busy", 32'(busy), 32'h0);
    checkOutput("len0_done", 32'(done), 32'h0);
    applyStimulus();
    checkOutput("len0_busy_later", 32'(busy), 32'h0);

    // Session len=3; the launching edge still performs the normal load
    golden = 4'b1111;
    d = 4'b0001; start = 1'b1; len = 8'd3;
    applyStimulus();
    start = 1'b0; d = 4'b0000;
    checkOutput("sess_launch_q", 32'(q), 32'h1);
    checkOutput("sess_busy1", 32'(busy), 32'h1);
    applyStimulus();
    checkOutput("sess_run1_q", 32'(q), 32'h3);
    checkOutput("sess_busy2", 32'(busy), 32'h1);
    // stray start during RUN must not change the length
    start = 1'b1; len = 8'd5;
    applyStimulus();
    start = 1'b0;
    checkOutput("sess_run2_q", 32'(q), 32'h7);
    checkOutput("sess_busy3", 32'(busy), 32'h1);
    applyStimulus();
    checkOutput("sess_final_q", 32'(q), 32'hF);
    checkOutput("sess_busy_end", 32'(busy), 32'h0);
    checkOutput("sess_done", 32'(done), 32'h1);
    checkOutput("sess_sig_match", 32'(sig_match), 32'(sig_hit()));

    // DONE holds for 5 cycles even with MISR selected
    b1 = 1'b1; b2 = 1'b0; d = 4'b0101;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("done_hold_q", 32'(q), 32'hF);
    checkOutput("done_hold_done", 32'(done), 32'h1);
    checkOutput("done_hold_sig", 32'(sig_match), 32'(sig_hit()));

    // Scan out of DONE: 1111 -> 1110, back to IDLE
    b1 = 1'b0; b2 = 1'b0; scan_in = 1'b0;
    applyStimulus();
    checkOutput("done_scan_q", 32'(q), 32'hE);
    checkOutput("done_scan_done", 32'(done), 32'h0);
    checkOutput("done_scan_sig", 32'(sig_match), 32'h0);

    // Session len=1: load 0000 then one MISR step with d=0011 -> 0011
    golden = 4'b0010;
    b1 = 1'b1; b2 = 1'b1; d = 4'b0000; start = 1'b1; len = 8'd1;
    applyStimulus();
    start = 1'b0; d = 4'b0011;
    checkOutput("len1_busy", 32'(busy), 32'h1);
    applyStimulus();
    checkOutput("len1_q", 32'(q), 32'h3);
    checkOutput("len1_done", 32'(done), 32'h1);
    checkOutput("len1_sig_miss", 32'(sig_match), 32'h0);

    // start beats scan in DONE; q holds, RUN for 2 cycles: 0011->0111->1111
    golden = 4'b1111;
    b1 = 1'b0; b2 = 1'b0; scan_in = 1'b1; start = 1'b1; len = 8'd2;
    applyStimulus();
    start = 1'b0; d = 4'b0000;
    checkOutput("prio_q", 32'(q), 32'h3);
    checkOutput("prio_busy", 32'(busy), 32'h1);
    checkOutput("prio_done", 32'(done), 32'h0);
    applyStimulus();
    applyStimulus();
    checkOutput("prio_final_q", 32'(q), 32'hF);
    checkOutput("prio_done_end", 32'(done), 32'h1);
    checkOutput("prio_sig", 32'(sig_match), 32'(sig_hit()));

    // Clear mode in DONE is not a scan request: hold
    b1 = 1'b0; b2 = 1'b1;
    applyStimulus();
    checkOutput("done_clear_hold", 32'(q), 32'hF);

    // Reset mid-RUN once the counter has reached 2
    start = 1'b1; len = 8'd4;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("mid_busy_before", 32'(busy), 32'h1);
    rst_l = 1'b0;
    #1;
    checkOutput("mid_rst_q", 32'(q), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_done", 32'(done), 32'h0);
    checkOutput("mid_rst_sig", 32'(sig_match), 32'h0);
    applyStimulus();
    rst_l = 1'b1;
    // IDLE scan gives 0001; a surviving RUN would compress d=0 into 0000
    b1 = 1'b0; b2 = 1'b0; scan_in = 1'b1; d = 4'b0000;
    applyStimulus();
    checkOutput("post_rst_q", 32'(q), 32'h1);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    checkOutput("post_rst_done", 32'(done), 32'h0);

    // Maximum length session
    b1 = 1'b1; b2 = 1'b1; start = 1'b1; len = 8'd255;
    applyStimulus();
    start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      busy_cycles++;
      applyStimulus();
    end
    checkOutput("max_len_cycles", 32'(busy_cycles), 32'd255);
    checkOutput("max_len_done", 32'(done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
